otube_reader: RTL and testbench

On-chip reader for the tube-data FIFO read port (OTUBE/RD_CLK/RD_EN/RD_EMPTY/RD_VALID). It is the read-side counterpart to the event writer and replaces the RPi GPIO master for loopback self-test and for a future UART/USB bridge. It drives the RD_CLK/RD_EN strobe protocol, captures each 16-bit word, checks the 32-word-plus-stop-flag event framing, and presents per-tube hits on a valid/ready stream.

---
 rtl/otube_pkg.sv | 33 +++
 rtl/otube_sync2.sv | 35 +++
 rtl/otube_reader.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_otube_reader.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otube_pkg.sv
// ----------------------------------------------------------------------------
// otube_pkg
//   Shared definitions for the tube-data FIFO reader:
//     state_t        reader FSM states
//     STOP_NAME      low byte that marks the end of an event
//     CHAMBER3/4     chamber nibble used in tube names
//     expected_name  tube name the writer emits for word index idx
// ----------------------------------------------------------------------------
package otube_pkg;

   typedef enum logic [2:0] {
      IDLE,
      STROBE_HI,
      STROBE_LO,
      WAIT_VALID,
      CHECK,
      EMIT,
      SKIP
   } state_t;

   localparam logic [7:0] STOP_NAME = 8'hFF;
   localparam logic [3:0] CHAMBER3  = 4'b0011;
   localparam logic [3:0] CHAMBER4  = 4'b0100;

   // Tubes 0..15 sit in chamber 3, the rest in chamber 4; the index bits
   // are rotated so the name matches the writer's wiring order.
   function automatic logic [7:0] expected_name(input logic [7:0] idx);
      logic [3:0] chamber;
      chamber = (idx < 8'd16) ? CHAMBER3 : CHAMBER4;
      return {idx[2:0], idx[3], chamber};
   endfunction

endpackage

// File: rtl/otube_sync2.sv
// ----------------------------------------------------------------------------
// otube_sync2
//   Two-flop synchronizer for a single asynchronous level.
//   Ports:
//     clk50  in   sampling clock
//     rst_n  in   asynchronous active-low reset
//     d      in   asynchronous input level
//     q      out  synchronized level (two clk50 cycles of latency)
//   Parameter RESET_VAL is the level both flops take in reset, so a
//   "FIFO empty" input can come out of reset in its safe state.
// ----------------------------------------------------------------------------
module otube_sync2
   import otube_pkg::*;
#(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk50,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/otube_reader.sv
// ----------------------------------------------------------------------------
// otube_reader
//   Read-side master for the tube-data FIFO. Strobes rd_clk/rd_en, captures
//   each 16-bit word when the synchronized rd_valid rises, checks the
//   NUM_TUBES-words-plus-stop-flag framing and hands tube hits to a
//   valid/ready consumer.
//
//   Ports:
//     clk50        in   sole clock
//     rst_n        in   asynchronous active-low reset
//     rd_clk       out  read strobe; FIFO pops on its rising edge
//     rd_en        out  read enable, qualifies rd_clk
//     rd_empty     in   FIFO empty (asynchronous, synchronized here)
//     rd_valid     in   word valid (asynchronous, synchronized here)
//     otube        in   [15:8] hit time, [7:0] tube name
//     hit_valid    out  hit record available
//     hit_ready    in   consumer accepts on hit_valid && hit_ready
//     hit_tube     out  tube name of the hit
//     hit_time     out  time of the hit
//     event_done   out  one-cycle pulse: stop flag closed a good event
//     event_count  out  number of good events, wraps at 16 bits
//     err_frame    out  one-cycle pulse: framing error
//     err_timeout  out  one-cycle pulse: no word arrived after a read
//
//   Build option:
//     OTUBE_READER_FRAME_CHECK_EN  when defined, every data word's tube name
//                                  must match expected_name(idx).
//
//   State table:
//     state      | meaning
//     IDLE       | waiting for data in the FIFO and no pending hit
//     STROBE_HI  | rd_clk/rd_en high, FIFO pops on entry
//     STROBE_LO  | rd_clk low, rd_en still high
//     WAIT_VALID | strobe done, waiting for the word (timeout running)
//     CHECK      | classify the captured word against the framing
//     EMIT       | hit presented, waiting for the handshake
//     SKIP       | resynchronizing: read and drop until a stop flag
// ----------------------------------------------------------------------------
module otube_reader
   import otube_pkg::*;
#(
   parameter int unsigned RD_CLK_HALF = 4,
   parameter int unsigned TIMEOUT     = 64,
   parameter int unsigned NUM_TUBES   = 32
) (
   input  logic        clk50,
   input  logic        rst_n,
   output logic        rd_clk,
   output logic        rd_en,
   input  logic        rd_empty,
   input  logic        rd_valid,
   input  logic [15:0] otube,
   output logic        hit_valid,
   input  logic        hit_ready,
   output logic [7:0]  hit_tube,
   output logic [7:0]  hit_time,
   output logic        event_done,
   output logic [15:0] event_count,
   output logic        err_frame,
   output logic        err_timeout
);

   localparam int unsigned PW = $clog2(RD_CLK_HALF + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam int unsigned IW = $clog2(NUM_TUBES + 1);

   localparam logic [PW-1:0] PH_LOAD  = PW'(RD_CLK_HALF - 1);
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_TUBES);

   logic valid_s;
   logic empty_s;
   logic valid_q;
   logic valid_rise;

   state_t        state_q,    state_d;
   logic [PW-1:0] ph_cnt_q,   ph_cnt_d;
   logic [TW-1:0] tmo_cnt_q,  tmo_cnt_d;
   logic [IW-1:0] idx_q,      idx_d;
   logic [15:0]   word_q,     word_d;
   logic          captured_q, captured_d;
   logic          skip_q,     skip_d;

   logic          rd_clk_d;
   logic          rd_en_d;
   logic          hit_valid_d;
   logic [7:0]    hit_tube_d;
   logic [7:0]    hit_time_d;
   logic          event_done_d;
   logic [15:0]   event_count_d;
   logic          err_frame_d;
   logic          err_timeout_d;

   logic          cap_now;
   logic          have_word;
   logic          ph_tc;
   logic          tmo_tc;
   logic          stop_flag;
   logic          name_ok;

   otube_sync2 #(.RESET_VAL(1'b0)) u_sync_valid (
      .clk50 (clk50),
      .rst_n (rst_n),
      .d     (rd_valid),
      .q     (valid_s)
   );

   // Empty resets high so no read can start before the real level arrives.
   otube_sync2 #(.RESET_VAL(1'b1)) u_sync_empty (
      .clk50 (clk50),
      .rst_n (rst_n),
      .d     (rd_empty),
      .q     (empty_s)
   );

   assign valid_rise = valid_s & ~valid_q;
   assign ph_tc      = (ph_cnt_q == '0);
   assign tmo_tc     = (tmo_cnt_q == '0);
   assign stop_flag  = (word_q[7:0] == STOP_NAME);

`ifdef OTUBE_READER_FRAME_CHECK_EN
   assign name_ok = (word_q[7:0] == expected_name(8'(idx_q)));
`else
   assign name_ok = 1'b1;
`endif

   always_comb begin
      state_d       = state_q;
      ph_cnt_d      = ph_cnt_q;
      tmo_cnt_d     = tmo_cnt_q;
      idx_d         = idx_q;
      word_d        = word_q;
      captured_d    = captured_q;
      skip_d        = skip_q;
      rd_clk_d      = 1'b0;
      rd_en_d       = 1'b0;
      hit_valid_d   = hit_valid;
      hit_tube_d    = hit_tube;
      hit_time_d    = hit_time;
      event_done_d  = 1'b0;
      event_count_d = event_count;
      err_frame_d   = 1'b0;
      err_timeout_d = 1'b0;
      cap_now       = 1'b0;
      have_word     = captured_q;

      // The word can show up while the strobe is still running; take the
      // first valid edge after the rd_clk rise and remember it.
      if (state_q inside {STROBE_HI, STROBE_LO, WAIT_VALID}) begin
         cap_now   = valid_rise & ~captured_q;
         have_word = captured_q | cap_now;
         if (cap_now) begin
            word_d     = otube;
            captured_d = 1'b1;
         end
         if (!tmo_tc) begin
            tmo_cnt_d = tmo_cnt_q - 1'b1;
         end
      end

      case (state_q)
         IDLE, SKIP: begin
            if (!empty_s && !hit_valid) begin
               state_d    = STROBE_HI;
               rd_clk_d   = 1'b1;
               rd_en_d    = 1'b1;
               ph_cnt_d   = PH_LOAD;
               tmo_cnt_d  = TMO_LOAD;
               captured_d = 1'b0;
            end
         end

         STROBE_HI: begin
            rd_en_d = 1'b1;
            if (ph_tc) begin
               state_d  = STROBE_LO;
               ph_cnt_d = PH_LOAD;
            end else begin
               rd_clk_d = 1'b1;
               ph_cnt_d = ph_cnt_q - 1'b1;
            end
         end

         STROBE_LO: begin
            if (ph_tc) begin
               state_d = have_word ? CHECK : WAIT_VALID;
            end else begin
               rd_en_d  = 1'b1;
               ph_cnt_d = ph_cnt_q - 1'b1;
            end
         end

         WAIT_VALID: begin
            if (have_word) begin
               state_d = CHECK;
            end else if (tmo_tc) begin
               err_timeout_d = 1'b1;
               idx_d         = '0;
               skip_d        = 1'b0;
               state_d       = IDLE;
            end
         end

         CHECK: begin
            captured_d = 1'b0;
            if (skip_q) begin
               if (stop_flag) begin
                  skip_d  = 1'b0;
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  state_d = SKIP;
               end
            end else if (idx_q < IDX_LAST) begin
               // An early stop flag ends the partial event right here, which
               // is also how the reader realigns after an abandoned event.
               if (stop_flag) begin
                  err_frame_d = 1'b1;
                  idx_d       = '0;
                  state_d     = IDLE;
               end else if (!name_ok) begin
                  err_frame_d = 1'b1;
                  skip_d      = 1'b1;
                  state_d     = SKIP;
               end else begin
                  hit_valid_d = 1'b1;
                  hit_tube_d  = word_q[7:0];
                  hit_time_d  = word_q[15:8];
                  idx_d       = idx_q + 1'b1;
                  state_d     = EMIT;
               end
            end else begin
               if (stop_flag) begin
                  event_done_d  = 1'b1;
                  event_count_d = event_count + 16'd1;
                  idx_d         = '0;
                  state_d       = IDLE;
               end else begin
                  err_frame_d = 1'b1;
                  skip_d      = 1'b1;
                  state_d     = SKIP;
               end
            end
         end

         EMIT: begin
            if (hit_ready) begin
               hit_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk50 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ph_cnt_q    <= '0;
         tmo_cnt_q   <= '0;
         idx_q       <= '0;
         word_q      <= '0;
         captured_q  <= 1'b0;
         skip_q      <= 1'b0;
         valid_q     <= 1'b0;
         rd_clk      <= 1'b0;
         rd_en       <= 1'b0;
         hit_valid   <= 1'b0;
         hit_tube    <= '0;
         hit_time    <= '0;
         event_done  <= 1'b0;
         event_count <= '0;
         err_frame   <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         ph_cnt_q    <= ph_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
         captured_q  <= captured_d;
         skip_q      <= skip_d;
         valid_q     <= valid_s;
         rd_clk      <= rd_clk_d;
         rd_en       <= rd_en_d;
         hit_valid   <= hit_valid_d;
         hit_tube    <= hit_tube_d;
         hit_time    <= hit_time_d;
         event_done  <= event_done_d;
         event_count <= event_count_d;
         err_frame   <= err_frame_d;
         err_timeout <= err_timeout_d;
      end
   end

endmodule

// File: tb/tb_otube_reader.sv
module tb_otube_reader;

   localparam int HALF = 4;
   localparam int TMO  = 64;
   localparam int NT   = 32;

   logic        clk50 = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_clk;
   logic        rd_en;
   logic        rd_empty = 1'b1;
   logic        rd_valid = 1'b0;
   logic [15:0] otube = 16'h0000;
   logic        hit_valid;
   logic        hit_ready = 1'b1;
   logic [7:0]  hit_tube;
   logic [7:0]  hit_time;
   logic        event_done;
   logic [15:0] event_count;
   logic        err_frame;
   logic        err_timeout;

   int n_checks = 0;
   int n_pass   = 0;

   // FIFO model state
   logic [15:0] fifo_q[$];
   logic [15:0] pend_word;
   logic        pending  = 1'b0;
   logic        no_valid = 1'b0;
   logic        rdc_prev = 1'b0;
   int          lat      = 0;

   // monitor state
   int cyc           = 0;
   int rd_rises      = 0;
   int last_rise_cyc = 0;
   int tmo_cyc       = 0;
   int n_done        = 0;
   int n_frame       = 0;
   int n_tmo         = 0;

   // consumer state
   logic [15:0] got_q[$];
   int          stall_at = -1;

   always #10 clk50 = ~clk50;

   otube_reader #(
      .RD_CLK_HALF (HALF),
      .TIMEOUT     (TMO),
      .NUM_TUBES   (NT)
   ) dut (
      .clk50       (clk50),
      .rst_n       (rst_n),
      .rd_clk      (rd_clk),
      .rd_en       (rd_en),
      .rd_empty    (rd_empty),
      .rd_valid    (rd_valid),
      .otube       (otube),
      .hit_valid   (hit_valid),
      .hit_ready   (hit_ready),
      .hit_tube    (hit_tube),
      .hit_time    (hit_time),
      .event_done  (event_done),
      .event_count (event_count),
      .err_frame   (err_frame),
      .err_timeout (err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] tname(input int i);
      logic [7:0] ib;
      ib = 8'(i);
      return {ib[2:0], ib[3], (i < 16) ? 4'b0011 : 4'b0100};
   endfunction

   task automatic load_event(input int n_data, input int bad_at);
      for (int i = 0; i < n_data; i++) begin
         fifo_q.push_back({8'(i + 1), (i == bad_at) ? 8'h23 : tname(i)});
      end
      fifo_q.push_back(16'hFFFF);
   endtask

   task automatic check_hits(input string tag, input int n, input int bad_at);
      logic [15:0] h;
      chk({tag, "_nhits"}, got_q.size(), n);
      for (int i = 0; i < n && i < got_q.size(); i++) begin
         h = got_q[i];
         chk({tag, "_tube"}, h[7:0], (i == bad_at) ? 8'h23 : tname(i));
         chk({tag, "_time"}, h[15:8], 8'(i + 1));
      end
   endtask

   task automatic settle(input string tag);
      int quiet = 0;
      int n = 0;
      while (quiet < 80 && n < 4000) begin
         @(negedge clk50);
         #2;
         n++;
         if (fifo_q.size() == 0 && !pending && !rd_en && !hit_valid) quiet++;
         else quiet = 0;
      end
      chk({tag, "_settle"}, (quiet >= 80), 1);
   endtask

   task automatic hold_and_release();
      repeat (3) @(posedge clk50);
      fifo_q.delete();
      pending  = 1'b0;
      rd_valid = 1'b0;
      no_valid = 1'b0;
      got_q.delete();
      n_done   = 0;
      n_frame  = 0;
      n_tmo    = 0;
      @(negedge clk50);
      rst_n = 1'b1;
      repeat (3) @(negedge clk50);
   endtask

   task automatic do_reset();
      @(negedge clk50);
      rst_n = 1'b0;
      hold_and_release();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rd_clk"}, rd_clk, 0);
      chk({tag, "_rd_en"}, rd_en, 0);
      chk({tag, "_hit_valid"}, hit_valid, 0);
      chk({tag, "_hit_tube"}, hit_tube, 0);
      chk({tag, "_hit_time"}, hit_time, 0);
      chk({tag, "_event_done"}, event_done, 0);
      chk({tag, "_event_count"}, event_count, 0);
      chk({tag, "_err_frame"}, err_frame, 0);
      chk({tag, "_err_timeout"}, err_timeout, 0);
   endtask

   // FIFO read port model plus output monitor; acts on the falling edge.
   initial begin
      forever begin
         @(negedge clk50);
         cyc++;
         if (rd_clk && !rdc_prev) begin
            rd_rises++;
            last_rise_cyc = cyc;
            if (rd_en && fifo_q.size() > 0) begin
               pend_word = fifo_q.pop_front();
               pending   = 1'b1;
               lat       = 3;
               rd_valid  = 1'b0;
            end
         end else if (pending) begin
            lat--;
            if (lat == 0) begin
               pending = 1'b0;
               if (!no_valid) begin
                  otube    = pend_word;
                  rd_valid = 1'b1;
               end
            end
         end
         rdc_prev = rd_clk;
         rd_empty = (fifo_q.size() == 0);
         if (event_done) n_done++;
         if (err_frame) n_frame++;
         if (err_timeout) begin
            n_tmo++;
            tmo_cyc = cyc;
         end
      end
   end

   // Hit consumer, with an optional 20-cycle stall on hit number stall_at.
   initial begin
      logic [7:0] s_tube;
      logic [7:0] s_time;
      int         s_rises;
      int         unstable;
      forever begin
         @(negedge clk50);
         if (hit_valid && stall_at >= 0 && got_q.size() == stall_at) begin
            hit_ready = 1'b0;
            s_tube    = hit_tube;
            s_time    = hit_time;
            #1;
            s_rises  = rd_rises;
            unstable = 0;
            repeat (20) begin
               @(negedge clk50);
               if (!hit_valid || hit_tube !== s_tube || hit_time !== s_time) unstable++;
            end
            #1;
            chk("stall_tube", s_tube, tname(stall_at));
            chk("stall_time", s_time, 8'(stall_at + 1));
            chk("stall_stable", unstable, 0);
            chk("stall_no_rd_rise", rd_rises - s_rises, 0);
            stall_at  = -1;
            hit_ready = 1'b1;
            got_q.push_back({hit_time, hit_tube});
         end else if (hit_valid && hit_ready) begin
            got_q.push_back({hit_time, hit_tube});
         end
      end
   end

   initial begin
      #(20 * 60000);
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int base;
      int n;
      int exp_hits;
      int exp_frame;
      int exp_done;
      int exp_count;

      rst_n = 1'b0;
      repeat (4) @(posedge clk50);
      @(negedge clk50);
      rst_n = 1'b1;
      repeat (5) @(negedge clk50);
      #2;
      check_reset_outputs("reset");

      // good event, consumer stalls on hit 5
      stall_at = 5;
      @(posedge clk50);
      load_event(NT, -1);
      settle("t1");
      check_hits("t1", NT, -1);
      chk("t1_done", n_done, 1);
      chk("t1_count", event_count, 1);
      chk("t1_frame", n_frame, 0);
      chk("t1_stall_taken", stall_at, -1);

      // stop flag at idx 10, then a good event
      do_reset();
      @(posedge clk50);
      load_event(10, -1);
      settle("t2a");
      chk("t2_frame", n_frame, 1);
      chk("t2_done", n_done, 0);
      chk("t2_hits", got_q.size(), 10);
      got_q.delete();
      n_frame = 0;
      @(posedge clk50);
      load_event(NT, -1);
      settle("t2b");
      check_hits("t2", NT, -1);
      chk("t2_count", event_count, 1);
      chk("t2_frame_after", n_frame, 0);

      // wrong name 8'h23 at idx 0, then a good event
      do_reset();
      @(posedge clk50);
      load_event(NT, 0);
      settle("t3a");
`ifdef OTUBE_READER_FRAME_CHECK_EN
      exp_hits  = 0;
      exp_frame = 1;
      exp_done  = 0;
      exp_count = 1;
`else
      exp_hits  = NT;
      exp_frame = 0;
      exp_done  = 1;
      exp_count = 2;
      check_hits("t3_nocheck", NT, 0);
`endif
      chk("t3_hits", got_q.size(), exp_hits);
      chk("t3_frame", n_frame, exp_frame);
      chk("t3_done", n_done, exp_done);
      got_q.delete();
      @(posedge clk50);
      load_event(NT, -1);
      settle("t3b");
      check_hits("t3", NT, -1);
      chk("t3_count", event_count, exp_count);

      // timeout after three words of an event, then a good event
      do_reset();
      @(posedge clk50);
      for (int i = 0; i < 3; i++) fifo_q.push_back({8'(i + 1), tname(i)});
      settle("t4a");
      chk("t4_partial_hits", got_q.size(), 3);
      no_valid = 1'b1;
      base = rd_rises;
      @(posedge clk50);
      fifo_q.push_back({8'h04, tname(3)});
      settle("t4b");
      chk("t4_tmo_count", n_tmo, 1);
      chk("t4_tmo_delay", tmo_cyc - last_rise_cyc, TMO);
      chk("t4_one_read", rd_rises - base, 1);
      chk("t4_frame", n_frame, 0);
      no_valid = 1'b0;
      got_q.delete();
      @(posedge clk50);
      load_event(NT, -1);
      settle("t4c");
      check_hits("t4", NT, -1);
      chk("t4_done", n_done, 1);
      chk("t4_count", event_count, 1);
      chk("t4_frame_after", n_frame, 0);

      // reset asserted during STROBE_HI of word 7
      do_reset();
      base = rd_rises;
      @(posedge clk50);
      load_event(NT, -1);
      n = 0;
      while (rd_rises < base + 8 && n < 2000) begin
         @(negedge clk50);
         #2;
         n++;
      end
      chk("t5_reached_word7", rd_rises - base, 8);
      chk("t5_rd_clk_high", rd_clk, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rd_clk_async", rd_clk, 0);
      chk("t5_rd_en_async", rd_en, 0);
      hold_and_release();
      repeat (30) @(negedge clk50);
      #2;
      check_reset_outputs("t5_after");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
